lbm_frame_scheduler: RTL and testbench
======================================

Name: lbm_frame_scheduler

Overview:
- Top-level timestep sequencer for the lattice-Boltzmann pipeline.
- Each step runs three phases in order:
  - LOAD: issues a DDR read command, then counts unpacked pixels (9×16-bit directions per pixel) into BRAM.
  - COMPUTE: pulses the collide/stream engine and waits for it to finish.
  - STORE: issues a DDR write-back command and waits for completion.
- Ping-pongs between two DDR frame banks and repeats for a programmed number of timesteps.

Parameters:
- DEPTH, 2500, pixels per frame (one 144-bit beat each)
- ADDRESS_WIDTH, 12, pixel counter/BRAM address width
- BEAT_BYTES, 18, bytes per pixel beat
- DDR_ADDR_WIDTH, 32, DDR byte-address width
- STEP_WIDTH, 16, timestep counter width
- TIMEOUT_CYCLES, 1048575, watchdog limit (only used with LBM_SCHED_TIMEOUT_EN)

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- start  in  1  start run; sampled in IDLE only
- abort  in  1  return to IDLE at next edge from any state
- num_steps  in  STEP_WIDTH  timesteps to run; latched on start
- bank0_base  in  DDR_ADDR_WIDTH  DDR byte address of bank 0; latched on start
- bank1_base  in  DDR_ADDR_WIDTH  DDR byte address of bank 1; latched on start
- rd_cmd_valid  out  1  DDR read command valid
- rd_cmd_ready  in  1  DDR read command accept
- rd_cmd_addr  out  DDR_ADDR_WIDTH  read base address
- rd_cmd_len  out  DDR_ADDR_WIDTH  read length in bytes (DEPTH*BEAT_BYTES)
- pix_wr_en  in  1  pulse per pixel written to BRAM by the unpacker
- pix_last  in  1  qualifies pix_wr_en; stream tlast
- compute_start  out  1  one-cycle start pulse to the compute engine
- compute_done  in  1  compute-engine completion pulse
- wr_cmd_valid  out  1  DDR write command valid
- wr_cmd_ready  in  1  DDR write command accept
- wr_cmd_addr  out  DDR_ADDR_WIDTH  write base address
- wr_cmd_len  out  DDR_ADDR_WIDTH  write length in bytes (same as read)
- wr_done  in  1  DDR write completion pulse
- bank_sel  out  1  current source bank (0/1)
- step_count  out  STEP_WIDTH  completed timesteps
- pix_count  out  ADDRESS_WIDTH  pixels loaded in the current LOAD phase
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a run completes
- len_err  out  1  sticky: frame length mismatch
- timeout_err  out  1  sticky: watchdog fired (tied 0 without the macro)

Behaviour:
- Reset: all outputs go to 0; state goes to IDLE; latched config goes to 0.
- States: IDLE, LOAD_CMD, LOAD, COMPUTE, STORE_CMD, STORE, FINISH.
- IDLE
  - On start: latch num_steps and both bank bases; clear step_count, bank_sel, len_err and timeout_err.
  - If num_steps==0, go to FINISH; otherwise go to LOAD_CMD.
- LOAD_CMD
  - rd_cmd_valid=1, with rd_cmd_addr = bank_sel ? bank1_base : bank0_base.
  - Address and length are held stable until the cycle where rd_cmd_valid && rd_cmd_ready; then go to LOAD and clear pix_count.
- LOAD
  - pix_count increments on each pix_wr_en.
  - Phase ends on pix_wr_en && (pix_last || pix_count==DEPTH-1).
  - If pix_last and pix_count!=DEPTH-1, or pix_count reaches DEPTH-1 without pix_last, set len_err. The run continues regardless.
  - On exit go to COMPUTE; compute_start pulses high for exactly the first cycle in COMPUTE.
- COMPUTE
  - Wait for compute_done, then go to STORE_CMD.
  - compute_done in the same cycle as compute_start is accepted.
- STORE_CMD
  - wr_cmd_valid=1, with wr_cmd_addr = the opposite bank base. Handshake rules are the same as LOAD_CMD.
  - After accept, go to STORE.
- STORE
  - On wr_done: step_count++ and toggle bank_sel.
  - If the new step_count==num_steps, go to FINISH; otherwise go to LOAD_CMD.
- FINISH
  - done=1 for one cycle, then go to IDLE.
- Latency: start to rd_cmd_valid is 1 cycle. Each phase transition takes 1 cycle after its qualifying input.
- Ignored inputs: compute_done and wr_done outside their own states; pix_wr_en outside LOAD; start while busy.
- abort has priority over all transitions, including a handshake completing in the same cycle.
  - On abort: cmd valids drop and the state goes to IDLE.
  - step_count, bank_sel and the error flags hold their values; done does not pulse.
- areset mid-run behaves identically to power-on reset.
- step_count wraps naturally at 2^STEP_WIDTH and cannot exceed num_steps.

Optional Feature:
- LBM_SCHED_TIMEOUT_EN defined:
  - A watchdog counter clears on every state change and increments otherwise in LOAD_CMD, LOAD, COMPUTE, STORE_CMD and STORE.
  - On reaching TIMEOUT_CYCLES it sets timeout_err and forces IDLE with no done pulse.
- Undefined: no counter is built, timeout_err is tied 0, and a stalled phase waits forever.

Test Plan:
- num_steps=2, bases 0x0000_0000/0x0001_0000, DEPTH ideal pixels with pix_last on the 2500th, prompt readies/dones:
  - rd addrs 0x0,0x10000; wr addrs 0x10000,0x0; both lens 45000.
  - step_count=2; done pulses once; len_err=0.
- rd_cmd_ready held low 10 cycles → rd_cmd_valid and rd_cmd_addr stable all 10 cycles; pix_count stays 0 until accept.
- pix_last on the 100th pixel → LOAD exits after 100 pixels; len_err=1; compute_start still pulses once.
- start with num_steps=0 → busy for 1 cycle (FINISH); done at cycle 2; no rd_cmd_valid.
- abort asserted in COMPUTE with step_count=1 → IDLE next cycle; step_count=1; no done; a new start restarts with step_count=0.
- With LBM_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, compute_done never asserted → timeout_err=1 after 64 cycles in COMPUTE; state returns to IDLE; busy=0.

Source files
------------

// File: rtl/lbm_frame_scheduler.sv
// Timestep sequencer for the lattice-Boltzmann pipeline: LOAD -> COMPUTE -> STORE per step, ping-ponging DDR banks.
// Optional watchdog enabled by defining LBM_SCHED_TIMEOUT_EN.
module lbm_frame_scheduler #(
  parameter int DEPTH          = 2500,
  parameter int ADDRESS_WIDTH  = 12,
  parameter int BEAT_BYTES     = 18,
  parameter int DDR_ADDR_WIDTH = 32,
  parameter int STEP_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [STEP_WIDTH-1:0]     num_steps,
  input  logic [DDR_ADDR_WIDTH-1:0] bank0_base,
  input  logic [DDR_ADDR_WIDTH-1:0] bank1_base,
  output logic                      rd_cmd_valid,
  input  logic                      rd_cmd_ready,
  output logic [DDR_ADDR_WIDTH-1:0] rd_cmd_addr,
  output logic [DDR_ADDR_WIDTH-1:0] rd_cmd_len,
  input  logic                      pix_wr_en,
  input  logic                      pix_last,
  output logic                      compute_start,
  input  logic                      compute_done,
  output logic                      wr_cmd_valid,
  input  logic                      wr_cmd_ready,
  output logic [DDR_ADDR_WIDTH-1:0] wr_cmd_addr,
  output logic [DDR_ADDR_WIDTH-1:0] wr_cmd_len,
  input  logic                      wr_done,
  output logic                      bank_sel,
  output logic [STEP_WIDTH-1:0]     step_count,
  output logic [ADDRESS_WIDTH-1:0]  pix_count,
  output logic                      busy,
  output logic                      done,
  output logic                      len_err,
  output logic                      timeout_err
);

  localparam logic [DDR_ADDR_WIDTH-1:0] FRAME_LEN = DDR_ADDR_WIDTH'(DEPTH * BEAT_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0]  LAST_PIX  = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_CMD  = 3'd1,
    LOAD      = 3'd2,
    COMPUTE   = 3'd3,
    STORE_CMD = 3'd4,
    STORE     = 3'd5,
    FINISH    = 3'd6
  } state_t;

  state_t                    state_r, state_s;
  logic [STEP_WIDTH-1:0]     num_steps_r, step_count_r, step_inc_s;
  logic [DDR_ADDR_WIDTH-1:0] bank0_r, bank1_r;
  logic [ADDRESS_WIDTH-1:0]  pix_count_r;
  logic                      bank_sel_r, len_err_r, cstart_r;
  logic                      wd_fire_s, kill_s, start_ok_s, at_last_s;

  assign step_inc_s = step_count_r + STEP_WIDTH'(1);
  assign at_last_s  = (pix_count_r == LAST_PIX);
  assign kill_s     = abort | wd_fire_s;
  assign start_ok_s = (state_r == IDLE) && start && !kill_s;

  // State register
  always_ff @(posedge aclk) begin
    if (areset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic; abort and the watchdog override every transition
  always_comb begin
    state_s = state_r;
    if (kill_s) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:      if (start) state_s = (num_steps == '0) ? FINISH : LOAD_CMD;
                   else       state_s = IDLE;
        LOAD_CMD:  if (rd_cmd_ready) state_s = LOAD;
                   else              state_s = LOAD_CMD;
        LOAD:      if (pix_wr_en && (pix_last || at_last_s)) state_s = COMPUTE;
                   else                                        state_s = LOAD;
        COMPUTE:   if (compute_done) state_s = STORE_CMD;
                   else              state_s = COMPUTE;
        STORE_CMD: if (wr_cmd_ready) state_s = STORE;
                   else              state_s = STORE_CMD;
        STORE:     if (wr_done) state_s = (step_inc_s == num_steps_r) ? FINISH : LOAD_CMD;
                   else         state_s = STORE;
        FINISH:    state_s = IDLE;
        default:   state_s = IDLE;
      endcase
    end
  end

  // Run configuration, step/bank bookkeeping, pixel counting and length check
  always_ff @(posedge aclk) begin
    if (areset) begin
      num_steps_r  <= '0;
      bank0_r      <= '0;
      bank1_r      <= '0;
      step_count_r <= '0;
      bank_sel_r   <= 1'b0;
      len_err_r    <= 1'b0;
      pix_count_r  <= '0;
      cstart_r     <= 1'b0;
    end else begin
      cstart_r <= (state_r == LOAD) && (state_s == COMPUTE);
      if (start_ok_s) begin
        num_steps_r  <= num_steps;
        bank0_r      <= bank0_base;
        bank1_r      <= bank1_base;
        step_count_r <= '0;
        bank_sel_r   <= 1'b0;
        len_err_r    <= 1'b0;
      end else if (!kill_s && (state_r == STORE) && wr_done) begin
        step_count_r <= step_inc_s;
        bank_sel_r   <= ~bank_sel_r;
      end else if (!kill_s && (state_r == LOAD) && pix_wr_en && (pix_last != at_last_s)) begin
        // Frame ended early, or hit DEPTH without tlast; flag it and carry on
        len_err_r <= 1'b1;
      end
      if (!kill_s && (state_r == LOAD_CMD) && rd_cmd_ready) pix_count_r <= '0;
      else if (!kill_s && (state_r == LOAD) && pix_wr_en)   pix_count_r <= pix_count_r + ADDRESS_WIDTH'(1);
    end
  end

`ifdef LBM_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_r;
  logic            wd_active_s, timeout_r;

  assign wd_active_s = (state_r != IDLE) && (state_r != FINISH);
  assign wd_fire_s   = wd_active_s && (wd_r == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_r;

  // Watchdog: counts cycles spent in the current active state
  always_ff @(posedge aclk) begin
    if (areset) begin
      wd_r      <= '0;
      timeout_r <= 1'b0;
    end else begin
      if ((state_s != state_r) || !wd_active_s) wd_r <= '0;
      else                                      wd_r <= wd_r + WD_W'(1);
      if (wd_fire_s)       timeout_r <= 1'b1;
      else if (start_ok_s) timeout_r <= 1'b0;
    end
  end
`else
  assign wd_fire_s   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign rd_cmd_valid  = (state_r == LOAD_CMD);
  assign wr_cmd_valid  = (state_r == STORE_CMD);
  assign rd_cmd_addr   = rd_cmd_valid ? (bank_sel_r ? bank1_r : bank0_r) : '0;
  assign wr_cmd_addr   = wr_cmd_valid ? (bank_sel_r ? bank0_r : bank1_r) : '0;
  assign rd_cmd_len    = rd_cmd_valid ? FRAME_LEN : '0;
  assign wr_cmd_len    = wr_cmd_valid ? FRAME_LEN : '0;
  assign compute_start = cstart_r;
  assign busy          = (state_r != IDLE);
  assign done          = (state_r == FINISH);
  assign bank_sel      = bank_sel_r;
  assign step_count    = step_count_r;
  assign pix_count     = pix_count_r;
  assign len_err       = len_err_r;

endmodule

// File: tb/tb_lbm_frame_scheduler.sv
// Self-checking bench for lbm_frame_scheduler: a per-cycle vector table plus directed multi-cycle runs.
module tb_lbm_frame_scheduler;

  logic        aclk = 1'b0;
  logic        areset, start, abort;
  logic [15:0] num_steps;
  logic [31:0] bank0_base, bank1_base;
  logic        rd_cmd_valid, rd_cmd_ready;
  logic [31:0] rd_cmd_addr, rd_cmd_len;
  logic        pix_wr_en, pix_last, compute_start, compute_done;
  logic        wr_cmd_valid, wr_cmd_ready;
  logic [31:0] wr_cmd_addr, wr_cmd_len;
  logic        wr_done, bank_sel;
  logic [15:0] step_count;
  logic [11:0] pix_count;
  logic        busy, done, len_err, timeout_err;

  lbm_frame_scheduler dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort), .num_steps(num_steps),
    .bank0_base(bank0_base), .bank1_base(bank1_base),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_len(rd_cmd_len), .pix_wr_en(pix_wr_en), .pix_last(pix_last),
    .compute_start(compute_start), .compute_done(compute_done),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_len(wr_cmd_len), .wr_done(wr_done), .bank_sel(bank_sel), .step_count(step_count),
    .pix_count(pix_count), .busy(busy), .done(done), .len_err(len_err), .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cs_cnt = 0;

  always @(negedge aclk) begin
    if (done)          done_cnt++;
    if (compute_start) cs_cnt++;
  end

  typedef struct {
    logic        start, abort, rd_rdy, pix_we, pix_lst, c_done, wr_rdy, w_done;
    logic [15:0] nsteps;
    logic        e_busy, e_rdv, e_wrv, e_cs, e_done, e_len, e_bank;
    logic [11:0] e_pix;
    logic [15:0] e_step;
    logic [31:0] e_rda, e_wra;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs;
    start = 1'b0; abort = 1'b0; rd_cmd_ready = 1'b0; pix_wr_en = 1'b0; pix_last = 1'b0;
    compute_done = 1'b0; wr_cmd_ready = 1'b0; wr_done = 1'b0;
  endtask

  task automatic do_reset;
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  task automatic feed(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      pix_wr_en = 1'b1;
      pix_last  = (i == last_at);
      tick();
    end
    pix_wr_en = 1'b0;
    pix_last  = 1'b0;
  endtask

  function automatic logic [127:0] pack_out(input logic b, rv, wv, cs, dn, le, bs,
                                            input logic [11:0] px, input logic [15:0] st,
                                            input logic [31:0] ra, wa);
    return {29'd0, b, rv, wv, cs, dn, le, bs, px, st, ra, wa};
  endfunction

  initial begin
    int d0, c0;
    //            st  ab  rr  pw  pl  cd  wr  wd  nsteps   bsy rdv wrv cs  dn  len bk  pix    step   rda           wra
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd1, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,12'd0,16'd0,32'h100,32'h0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd1, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,12'd0,16'd0,32'h100,32'h0};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'd1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'd0,16'd0,32'h0,32'h0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'd1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'd1,16'd0,32'h0,32'h0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'd1,16'd0,32'h0,32'h0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,16'd1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'd2,16'd0,32'h0,32'h0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,16'd1, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,12'd3,16'd0,32'h0,32'h0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,16'd1, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,12'd3,16'd0,32'h0,32'h200};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd1, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,12'd3,16'd0,32'h0,32'h200};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'd1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,12'd3,16'd0,32'h0,32'h0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd1, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,12'd3,16'd1,32'h0,32'h0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,12'd3,16'd1,32'h0,32'h0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,12'd3,16'd0,32'h0,32'h0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'd3,16'd0,32'h0,32'h0};
    vecs[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd5, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'd3,16'd0,32'h0,32'h0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd1, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,12'd3,16'd0,32'h100,32'h0};
    vecs[16] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,12'd3,16'd0,32'h0,32'h0};

    clear_inputs();
    num_steps = 16'd0; bank0_base = 32'h0; bank1_base = 32'h0;
    do_reset();
    chk("reset_outputs",
        pack_out(busy, rd_cmd_valid, wr_cmd_valid, compute_start, done, len_err, bank_sel,
                 pix_count, step_count, rd_cmd_addr, wr_cmd_addr),
        128'd0);
    chk("reset_lens_timeout", {rd_cmd_len, wr_cmd_len, 31'd0, timeout_err}, 128'd0);

    // Short single-step run with an early tlast, ignored inputs, zero-step run and aborts
    bank0_base = 32'h100; bank1_base = 32'h200;
    for (int i = 0; i < 17; i++) begin
      start = vecs[i].start; abort = vecs[i].abort; rd_cmd_ready = vecs[i].rd_rdy;
      pix_wr_en = vecs[i].pix_we; pix_last = vecs[i].pix_lst; compute_done = vecs[i].c_done;
      wr_cmd_ready = vecs[i].wr_rdy; wr_done = vecs[i].w_done; num_steps = vecs[i].nsteps;
      tick();
      chk($sformatf("vec%0d", i),
          pack_out(busy, rd_cmd_valid, wr_cmd_valid, compute_start, done, len_err, bank_sel,
                   pix_count, step_count, rd_cmd_addr, wr_cmd_addr),
          pack_out(vecs[i].e_busy, vecs[i].e_rdv, vecs[i].e_wrv, vecs[i].e_cs, vecs[i].e_done,
                   vecs[i].e_len, vecs[i].e_bank, vecs[i].e_pix, vecs[i].e_step,
                   vecs[i].e_rda, vecs[i].e_wra));
    end
    clear_inputs();

    // Full two-step run with ideal frames
    d0 = done_cnt; c0 = cs_cnt;
    num_steps = 16'd2; bank0_base = 32'h0000_0000; bank1_base = 32'h0001_0000;
    start = 1'b1; tick(); start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("full_rd%0d", s), {rd_cmd_valid, rd_cmd_addr, rd_cmd_len},
          {1'b1, (s == 0) ? 32'h0 : 32'h10000, 32'd45000});
      rd_cmd_ready = 1'b1; tick(); rd_cmd_ready = 1'b0;
      feed(2500, 2499);
      chk($sformatf("full_load%0d", s), {compute_start, pix_count, len_err}, {1'b1, 12'd2500, 1'b0});
      compute_done = 1'b1; tick(); compute_done = 1'b0;
      chk($sformatf("full_wr%0d", s), {wr_cmd_valid, wr_cmd_addr, wr_cmd_len},
          {1'b1, (s == 0) ? 32'h10000 : 32'h0, 32'd45000});
      wr_cmd_ready = 1'b1; tick(); wr_cmd_ready = 1'b0;
      wr_done = 1'b1; tick(); wr_done = 1'b0;
      chk($sformatf("full_step%0d", s), {step_count, bank_sel}, {16'(s + 1), 1'(s + 1)});
    end
    chk("full_done", {done, busy}, {1'b1, 1'b1});
    tick();
    chk("full_end", {busy, step_count, len_err, 32'(done_cnt - d0), 32'(cs_cnt - c0)},
        {1'b0, 16'd2, 1'b0, 32'd1, 32'd2});

    // Stalled read command after a reset, then a missing tlast, then abort in COMPUTE
    do_reset();
    chk("reset_midrun", {busy, step_count, bank_sel, pix_count, rd_cmd_valid}, 128'd0);
    num_steps = 16'd3; bank0_base = 32'h1000; bank1_base = 32'h2000;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix_wr_en = 1'b1;
      tick();
      chk($sformatf("stall%0d", i), {rd_cmd_valid, rd_cmd_addr, rd_cmd_len, pix_count},
          {1'b1, 32'h1000, 32'd45000, 12'd0});
    end
    pix_wr_en = 1'b0;
    rd_cmd_ready = 1'b1; tick(); rd_cmd_ready = 1'b0;
    feed(2500, 2499);
    compute_done = 1'b1; tick(); compute_done = 1'b0;
    wr_cmd_ready = 1'b1; tick(); wr_cmd_ready = 1'b0;
    wr_done = 1'b1; tick(); wr_done = 1'b0;
    chk("step2_rd", {rd_cmd_valid, rd_cmd_addr, step_count, len_err}, {1'b1, 32'h2000, 16'd1, 1'b0});
    rd_cmd_ready = 1'b1; tick(); rd_cmd_ready = 1'b0;
    feed(2500, -1);
    chk("no_tlast", {compute_start, pix_count, len_err}, {1'b1, 12'd2500, 1'b1});
    d0 = done_cnt;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_hold", {busy, step_count, bank_sel, len_err}, {1'b0, 16'd1, 1'b1, 1'b1});
    tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    num_steps = 16'd1;
    start = 1'b1; tick(); start = 1'b0;
    chk("restart", {busy, step_count, bank_sel, len_err, rd_cmd_valid, rd_cmd_addr},
        {1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 32'h1000});
    chk("timeout_tied", {31'd0, timeout_err}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
